// File: rtl/ef_adc1008_pkg.sv
// Shared types and constants for the ADC1008 SAR controller.
package ef_adc1008_pkg;

   localparam int unsigned RES_W = 10;
   localparam int unsigned CH_W  = 3;
   localparam int unsigned N_CH  = 8;

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      CONV,
      DONE
   } state_e;

endpackage

// File: rtl/ef_adc1008_ch_sel.sv
// Next set bit of a channel mask above (or at, with i_incl) an index.
// With no such bit, o_wrap is set and o_idx is the lowest set bit.
module ef_adc1008_ch_sel
   import ef_adc1008_pkg::*;
(
   input  logic [N_CH-1:0] i_mask,
   input  logic [CH_W-1:0] i_idx,
   input  logic            i_incl,
   output logic [CH_W-1:0] o_idx,
   output logic            o_wrap,
   output logic            o_any
);

   logic [CH_W-1:0] w_low;

   // Descending scan so the lowest qualifying bit is written last.
   always_comb begin
      o_idx  = '0;
      o_wrap = 1'b1;
      w_low  = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (i_mask[i]) begin
            w_low = CH_W'(i);
            if ((CH_W'(i) > i_idx) || (i_incl && (CH_W'(i) == i_idx))) begin
               o_idx  = CH_W'(i);
               o_wrap = 1'b0;
            end
         end
      end
      if (o_wrap) begin
         o_idx = w_low;
      end
   end

   assign o_any = |i_mask;

endmodule

// File: rtl/ef_adc1008_sar_ctrl.sv
// Successive-approximation controller for the 8-channel, 10-bit SAR ADC macro,
// with mask-driven channel scanning and a valid/ready result port.
module ef_adc1008_sar_ctrl
   import ef_adc1008_pkg::*;
#(
   parameter int unsigned SETTLE = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_start,
   input  logic             i_cont,
   input  logic [N_CH-1:0]  i_ch_mask,
   input  logic [7:0]       i_sample_cycles,
   output logic [RES_W-1:0] o_res_data,
   output logic [CH_W-1:0]  o_res_ch,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic             o_busy,
   output logic             o_adc_en,
   output logic             o_adc_rst,
   output logic [CH_W-1:0]  o_adc_b,
   output logic             o_adc_hold,
   output logic [RES_W-1:0] o_adc_data,
   input  logic             i_adc_cmp
);

   localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE - 1);
   localparam logic [3:0]       BIT_MSB   = 4'(RES_W - 1);
   localparam logic [RES_W-1:0] ONE       = RES_W'(1);

   state_e           r_state, w_state_nxt;
   logic [7:0]       r_cnt, w_cnt_nxt;
   logic [3:0]       r_bit, w_bit_nxt;
   logic [RES_W-1:0] r_result, w_result_nxt;
   logic [N_CH-1:0]  r_pass_mask, w_pass_mask_nxt;
   logic             r_cont, w_cont_nxt;
   logic [CH_W-1:0]  r_ch, w_ch_nxt;
   logic [1:0]       r_sync;
   logic             r_adc_en;

   logic [7:0]       w_smp_len;
   logic [RES_W-1:0] w_trial;
   logic [CH_W-1:0]  w_first_idx, w_next_idx;
   logic             w_first_wrap, w_first_any;
   logic             w_next_wrap, w_next_any;

   ef_adc1008_ch_sel u_first_sel (
      .i_mask (i_ch_mask),
      .i_idx  ('0),
      .i_incl (1'b1),
      .o_idx  (w_first_idx),
      .o_wrap (w_first_wrap),
      .o_any  (w_first_any)
   );

   ef_adc1008_ch_sel u_next_sel (
      .i_mask (r_pass_mask),
      .i_idx  (r_ch),
      .i_incl (1'b0),
      .o_idx  (w_next_idx),
      .o_wrap (w_next_wrap),
      .o_any  (w_next_any)
   );

   // Counter holds remaining cycles minus one; a zero length still takes one cycle.
   assign w_smp_len = (i_sample_cycles == 8'd0) ? 8'd0 : i_sample_cycles - 8'd1;
   assign w_trial   = r_result | (ONE << r_bit);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_result    <= '0;
         r_pass_mask <= '0;
         r_cont      <= 1'b0;
         r_ch        <= '0;
         r_sync      <= '0;
         r_adc_en    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit       <= w_bit_nxt;
         r_result    <= w_result_nxt;
         r_pass_mask <= w_pass_mask_nxt;
         r_cont      <= w_cont_nxt;
         r_ch        <= w_ch_nxt;
         r_sync      <= {r_sync[0], i_adc_cmp};
         r_adc_en    <= i_en;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_bit_nxt       = r_bit;
      w_result_nxt    = r_result;
      w_pass_mask_nxt = r_pass_mask;
      w_cont_nxt      = r_cont;
      w_ch_nxt        = r_ch;
      unique case (r_state)
         IDLE: begin
            if (i_start && w_first_any) begin
               w_pass_mask_nxt = i_ch_mask;
               w_cont_nxt      = i_cont;
               w_ch_nxt        = w_first_idx;
               w_cnt_nxt       = w_smp_len;
               w_state_nxt     = SAMPLE;
            end
         end
         SAMPLE: begin
            if (r_cnt == 8'd0) begin
               w_cnt_nxt    = SETTLE_M1;
               w_bit_nxt    = BIT_MSB;
               w_result_nxt = '0;
               w_state_nxt  = CONV;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         CONV: begin
            if (r_cnt == 8'd0) begin
               w_result_nxt[r_bit] = r_sync[1];
               if (r_bit == 4'd0) begin
                  w_state_nxt = DONE;
               end else begin
                  w_bit_nxt = r_bit - 4'd1;
                  w_cnt_nxt = SETTLE_M1;
               end
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         DONE: begin
            if (i_res_ready) begin
               if (w_next_any && !w_next_wrap) begin
                  w_ch_nxt    = w_next_idx;
                  w_cnt_nxt   = w_smp_len;
                  w_state_nxt = SAMPLE;
               end else if (r_cont && w_first_any) begin
                  w_pass_mask_nxt = i_ch_mask;
                  w_cont_nxt      = i_cont;
                  w_ch_nxt        = w_first_idx;
                  w_cnt_nxt       = w_smp_len;
                  w_state_nxt     = SAMPLE;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
      endcase
      if (!i_en) begin
         w_state_nxt = IDLE;
      end
   end

   always_comb begin
      o_res_data  = r_result;
      o_res_ch    = r_ch;
      o_res_valid = (r_state == DONE);
      o_busy      = (r_state != IDLE);
      o_adc_en    = r_adc_en;
      o_adc_rst   = (r_state == IDLE);
      o_adc_b     = r_ch;
      o_adc_hold  = (r_state == CONV) || (r_state == DONE);
      o_adc_data  = '0;
      unique case (r_state)
         IDLE:   o_adc_data = '0;
         SAMPLE: o_adc_data = '0;
         CONV:   o_adc_data = w_trial;
         DONE:   o_adc_data = r_result;
      endcase
   end

endmodule

// File: tb/tb_ef_adc1008_sar_ctrl.sv
// Directed bench for ef_adc1008_sar_ctrl with a behavioural ADC macro model
// (comparator = held input > DAC code, input in LSB units).
module tb_ef_adc1008_sar_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic [7:0] ch_mask = 8'h00;
   logic [7:0] sample_cycles = 8'd4;
   logic [9:0] res_data;
   logic [2:0] res_ch;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic       busy;
   logic       adc_en;
   logic       adc_rst;
   logic [2:0] adc_b;
   logic       adc_hold;
   logic [9:0] adc_data;
   logic       adc_cmp;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int viol = 0;
   logic [2:0] prev_b = 3'd0;
   int vin [8];
   int held = 0;

   ef_adc1008_sar_ctrl #(.SETTLE(4)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_en            (en),
      .i_start         (start),
      .i_cont          (cont),
      .i_ch_mask       (ch_mask),
      .i_sample_cycles (sample_cycles),
      .o_res_data      (res_data),
      .o_res_ch        (res_ch),
      .o_res_valid     (res_valid),
      .i_res_ready     (res_ready),
      .o_busy          (busy),
      .o_adc_en        (adc_en),
      .o_adc_rst       (adc_rst),
      .o_adc_b         (adc_b),
      .o_adc_hold      (adc_hold),
      .o_adc_data      (adc_data),
      .i_adc_cmp       (adc_cmp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge adc_hold) held = vin[adc_b];
   assign adc_cmp = (held > int'(adc_data));

   always @(negedge clk) begin
      if (adc_hold && adc_b !== prev_b) viol <= viol + 1;
      prev_b <= adc_b;
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts negedges after the start edge until res_valid is seen (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!res_valid && n < 300);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", res_valid); end
      total++; if (res_data !== 10'h000) begin bad++; $display("FAIL reset_data got=%0h want=0", res_data); end
      total++; if (adc_en !== 1'b0) begin bad++; $display("FAIL reset_adc_en got=%0h want=0", adc_en); end
      total++; if (adc_rst !== 1'b1) begin bad++; $display("FAIL reset_adc_rst got=%0h want=1", adc_rst); end
      total++; if (adc_hold !== 1'b0 || adc_data !== 10'h000 || adc_b !== 3'd0)
         begin bad++; $display("FAIL reset_adc_lines got=%0h/%0h/%0h want=0/0/0", adc_hold, adc_data, adc_b); end
      rst = 1'b0;
      en  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++; if (adc_en !== 1'b1) begin bad++; $display("FAIL adc_en_follow got=%0h want=1", adc_en); end
   endtask

   task automatic test_single();
      int n;
      ch_mask = 8'h08; cont = 1'b0; sample_cycles = 8'd4; res_ready = 1'b1;
      pulse_start();
      wait_valid(n);
      total++; if (n !== 45) begin bad++; $display("FAIL single_latency got=%0d want=45", n); end
      total++; if (res_ch !== 3'd3) begin bad++; $display("FAIL single_ch got=%0d want=3", res_ch); end
      total++; if (res_data !== 10'h1FF) begin bad++; $display("FAIL single_data got=%0h want=1ff", res_data); end
      @(negedge clk);
      total++; if (busy !== 1'b0 || adc_rst !== 1'b1)
         begin bad++; $display("FAIL single_idle got busy=%0h rst=%0h want 0/1", busy, adc_rst); end
   endtask

   task automatic test_scan();
      int n;
      int t0;
      int t1;
      int t2;
      ch_mask = 8'h91; cont = 1'b0; res_ready = 1'b1;
      viol = 0;
      pulse_start();
      wait_valid(n);
      t0 = cyc;
      total++; if (res_ch !== 3'd0 || res_data !== 10'd99)
         begin bad++; $display("FAIL scan_r0 got ch=%0d d=%0d want 0/99", res_ch, res_data); end
      wait_valid(n);
      t1 = cyc;
      total++; if (res_ch !== 3'd4 || res_data !== 10'h3FF)
         begin bad++; $display("FAIL scan_r1 got ch=%0d d=%0h want 4/3ff", res_ch, res_data); end
      total++; if (t1 - t0 !== 45) begin bad++; $display("FAIL scan_gap1 got=%0d want=45", t1 - t0); end
      wait_valid(n);
      t2 = cyc;
      total++; if (res_ch !== 3'd7 || res_data !== 10'h000)
         begin bad++; $display("FAIL scan_r2 got ch=%0d d=%0h want 7/0", res_ch, res_data); end
      total++; if (t2 - t1 !== 45) begin bad++; $display("FAIL scan_gap2 got=%0d want=45", t2 - t1); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL scan_idle got=%0h want=0", busy); end
      total++; if (viol !== 0) begin bad++; $display("FAIL scan_b_under_hold got=%0d want=0", viol); end
   endtask

   task automatic test_backpressure();
      int n;
      int unstable = 0;
      ch_mask = 8'h03; cont = 1'b0; res_ready = 1'b0;
      pulse_start();
      wait_valid(n);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_data !== 10'd99 || res_ch !== 3'd0 || adc_hold !== 1'b1)
            unstable++;
      end
      total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", unstable); end
      res_ready = 1'b1;
      @(negedge clk);
      total++; if (adc_hold !== 1'b0 || adc_b !== 3'd1 || res_valid !== 1'b0)
         begin bad++; $display("FAIL bp_next_sample got hold=%0h b=%0d v=%0h want 0/1/0", adc_hold, adc_b, res_valid); end
      wait_valid(n);
      total++; if (res_ch !== 3'd1 || res_data !== 10'd699)
         begin bad++; $display("FAIL bp_r1 got ch=%0d d=%0d want 1/699", res_ch, res_data); end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int n;
      int seen = 0;
      ch_mask = 8'h04; cont = 1'b0; res_ready = 1'b1;
      pulse_start();
      repeat (22) @(negedge clk);
      en = 1'b0;
      #1;
      total++; if (adc_data !== 10'h120) begin bad++; $display("FAIL abort_trial got=%0h want=120", adc_data); end
      total++; if (adc_en !== 1'b1) begin bad++; $display("FAIL abort_en_delay got=%0h want=1", adc_en); end
      @(negedge clk);
      total++; if (busy !== 1'b0 || adc_en !== 1'b0)
         begin bad++; $display("FAIL abort_idle got busy=%0h en=%0h want 0/0", busy, adc_en); end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d want=0", seen); end
      en = 1'b1;
      @(negedge clk);
      pulse_start();
      wait_valid(n);
      total++; if (n !== 45 || res_ch !== 3'd2 || res_data !== 10'd299)
         begin bad++; $display("FAIL abort_restart got n=%0d ch=%0d d=%0d want 45/2/299", n, res_ch, res_data); end
      @(negedge clk);
   endtask

   task automatic test_cont();
      int n;
      ch_mask = 8'h03; cont = 1'b1; res_ready = 1'b1;
      pulse_start();
      wait_valid(n);
      total++; if (res_ch !== 3'd0 || res_data !== 10'd99)
         begin bad++; $display("FAIL cont_r0 got ch=%0d d=%0d want 0/99", res_ch, res_data); end
      ch_mask = 8'h04; cont = 1'b0;
      wait_valid(n);
      total++; if (res_ch !== 3'd1 || res_data !== 10'd699)
         begin bad++; $display("FAIL cont_r1 got ch=%0d d=%0d want 1/699", res_ch, res_data); end
      wait_valid(n);
      total++; if (res_ch !== 3'd2 || res_data !== 10'd299)
         begin bad++; $display("FAIL cont_r2 got ch=%0d d=%0d want 2/299", res_ch, res_data); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_end got=%0h want=0", busy); end
   endtask

   task automatic test_rst_mid();
      ch_mask = 8'h80; cont = 1'b0;
      pulse_start();
      repeat (2) @(negedge clk);
      total++; if (adc_b !== 3'd7 || busy !== 1'b1)
         begin bad++; $display("FAIL rstmid_pre got b=%0d busy=%0h want 7/1", adc_b, busy); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 10'h000 || res_ch !== 3'd0 ||
                   adc_en !== 1'b0 || adc_rst !== 1'b1 || adc_b !== 3'd0 || adc_hold !== 1'b0 ||
                   adc_data !== 10'h000)
         begin bad++; $display("FAIL rstmid_vals got busy=%0h v=%0h d=%0h ch=%0d en=%0h rst=%0h b=%0d h=%0h dac=%0h want 0/0/0/0/0/1/0/0/0",
                               busy, res_valid, res_data, res_ch, adc_en, adc_rst, adc_b, adc_hold, adc_data); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_edges();
      int n;
      ch_mask = 8'h01; cont = 1'b0; sample_cycles = 8'd0; res_ready = 1'b1;
      pulse_start();
      wait_valid(n);
      total++; if (n !== 42 || res_data !== 10'd99)
         begin bad++; $display("FAIL zero_sample got n=%0d d=%0d want 42/99", n, res_data); end
      @(negedge clk);
      sample_cycles = 8'd4;
      ch_mask = 8'h00;
      pulse_start();
      @(negedge clk);
      total++; if (busy !== 1'b0 || adc_rst !== 1'b1)
         begin bad++; $display("FAIL zero_mask got busy=%0h rst=%0h want 0/1", busy, adc_rst); end
   endtask

   initial begin
      vin[0] = 100; vin[1] = 700; vin[2] = 300; vin[3] = 512;
      vin[4] = 1024; vin[5] = 0; vin[6] = 0; vin[7] = 0;
      test_reset();
      test_single();
      test_scan();
      test_backpressure();
      test_abort();
      test_cont();
      test_rst_mid();
      test_edges();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ef_adc1008_sar_ctrl.md
# ef_adc1008_sar_ctrl

Synchronous successive-approximation controller for the 8-channel, 10-bit SAR ADC analog macro. It drives the macro's channel select, hold, enable, reset and DAC code lines, and resolves one 10-bit result per conversion from the comparator output. It can scan channels from a mask in single-pass or continuous mode. Results go to the bus-side register block through a valid/ready handshake.

## Interface
- SETTLE, 4: cycles per bit trial, counted from the DAC code change to the comparator sample; legal values 3..15.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  controller enable; low forces IDLE.
- start  in  1  one-cycle pulse; begins a pass when the controller is in IDLE.
- cont  in  1  1 = continuous scan, 0 = single pass.
- ch_mask  in  8  channels to convert; bit i is VIN[i].
- sample_cycles  in  8  sample (track) length in cycles; 0 is treated as 1.
- res_data  out  10  conversion result.
- res_ch  out  3  channel of res_data.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  state is not IDLE.
- adc_en  out  1  to the macro's EN; equals en registered.
- adc_rst  out  1  to the macro's RST; high in IDLE, low otherwise.
- adc_b  out  3  to the macro's B (channel select).
- adc_hold  out  1  to the macro's HOLD; its rising edge captures the input.
- adc_data  out  10  to the macro's DAC code DATA.
- adc_cmp  in  1  macro comparator; asynchronous, 1 means held input > DAC output.

## Operation
- The state machine has four states: IDLE, SAMPLE, CONV and DONE.
- IDLE:
  - start with en=1 and ch_mask≠0 latches ch_mask into pass_mask.
  - adc_b is set to the lowest set bit of pass_mask, then the state moves to SAMPLE.
  - start with ch_mask=0 is ignored.
- SAMPLE:
  - adc_hold=0 and adc_data=0.
  - Lasts max(sample_cycles,1) cycles, then the state moves to CONV.
- CONV:
  - adc_hold=1 from the first CONV cycle; this is the rising edge.
  - Bit k runs from 9 down to 0.
  - For each bit, adc_data = result | (1<<k) for SETTLE cycles.
  - On the last cycle of the bit, the synchronized cmp is sampled. If it is 1, bit k is kept; if 0, it is cleared.
  - After bit 0 the state moves to DONE.
- DONE:
  - res_valid=1, with res_data and res_ch stable.
  - adc_hold stays 1 and adc_data holds the final code.
  - The handshake completes on res_valid & res_ready.
  - Next channel is the next set bit of pass_mask above the current one.
  - If one exists, the controller goes to SAMPLE on it.
  - If none exists: with cont=1 it re-latches ch_mask (a zero mask → IDLE) and goes to the lowest set bit; with cont=0 it goes to IDLE.
- adc_cmp goes through a 2-flop synchronizer. SETTLE≥3 covers DAC settling plus synchronizer latency.
- Backpressure: the controller stalls in DONE indefinitely. No new sample is taken and no result is dropped.
- ch_mask and cont changes take effect only at pass boundaries. sample_cycles is read on SAMPLE entry.
- en=0 in any state:
  - The next state is IDLE and res_valid drops the next cycle; the partial result is discarded.
  - adc_en follows en with a 1-cycle delay.

## Timing
- Reset values:
  - State IDLE, busy=0, res_valid=0, res_data=0, res_ch=0.
  - adc_en=0, adc_rst=1, adc_b=0, adc_hold=0, adc_data=0, and the synchronizer is cleared.
- Reset mid-operation takes priority over all other inputs and returns the controller to the reset values on the next edge.
- First conversion timing:
  - start is sampled at edge t; SAMPLE occupies t+1 .. t+S, where S = max(sample_cycles,1).
  - CONV starts at t+S+1 and lasts 10·SETTLE cycles.
  - res_valid rises at t+S+1+10·SETTLE. With S=4 and SETTLE=4 this is t+45.
- Back-to-back: the handshake at edge u puts the next channel in SAMPLE at u+1. Steady throughput is 1+S+10·SETTLE cycles per result when res_ready is held high.
- adc_b changes only on SAMPLE entry; it is never changed while adc_hold=1.
- start while busy is ignored.
- start and en=0 in the same cycle: en wins.

## Structure
- Package ef_adc1008_pkg holds:
  - State enum: IDLE, SAMPLE, CONV, DONE.
  - Constants RES_W=10, CH_W=3, N_CH=8.
- Sub-module ef_adc1008_ch_sel is combinational next-set-bit-above-index logic with wrap indication.
- It serves both first-channel and next-channel selection.
- The synchronizer, counters and result register stay in the top module.

## Test plan
- Single channel:
  - Stimulus: mask=0x08, cont=0, VIN[3]=0.5·(VH−VL) with the macro's offset cleared by adc_rst, res_ready=1.
  - Response: one result, res_ch=3, res_data=0x1FF or 0x200, res_valid at t+45; then IDLE, busy=0, adc_rst=1.
- Scan:
  - Stimulus: mask=0x91, cont=0.
  - Response: results in order ch0, ch4, ch7, each 45 cycles apart (S=4, SETTLE=4); adc_b is never changed while adc_hold=1.
- Backpressure:
  - Stimulus: res_ready low for 20 cycles in DONE.
  - Response: res_valid, res_data and res_ch are stable; adc_hold=1 and there is no SAMPLE entry; after the accept, SAMPLE starts the next cycle.
- Abort:
  - Stimulus: en dropped during bit 5 of CONV.
  - Response: IDLE next cycle, no res_valid, adc_en=0 one cycle later; a new start converts correctly.
- Continuous and reset:
  - Stimulus: cont=1, mask=0x03, then mask changed to 0x04 mid-pass.
  - Response: the pass finishes ch0 and ch1, then converts ch2 only.
  - Stimulus: rst during SAMPLE. Response: all outputs equal the reset values on the next cycle.
- Edge cases:
  - sample_cycles=0 gives a 1-cycle SAMPLE.
  - Code extremes: VIN=VL → 0x000, VIN≥VH → 0x3FF.
  - start with ch_mask=0 leaves busy=0.
